// File: rtl/apb_master_if.sv
// Processor-side command/response port and APB requester signals of apb_master.
// The master modport is the apb_master view; slave is the command source and APB responder side.
interface apb_master_if #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 4
);
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic                  cmd_write_i;
   logic [ADDR_WIDTH-1:0] cmd_addr_i;
   logic [DATA_WIDTH-1:0] cmd_wdata_i;
   logic                  rsp_valid_o;
   logic [DATA_WIDTH-1:0] rsp_rdata_o;
   logic                  rsp_err_o;
   logic                  rsp_timeout_o;
   logic                  psel_o;
   logic                  penable_o;
   logic                  pwrite_o;
   logic [ADDR_WIDTH-1:0] paddr_o;
   logic [DATA_WIDTH-1:0] pwdata_o;
   logic [DATA_WIDTH-1:0] prdata_i;
   logic                  pready_i;
   logic                  pslverr_i;

   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, prdata_i, pready_i, pslverr_i,
      output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
   );

   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, prdata_i, pready_i, pslverr_i,
      input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
      input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
   );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: IDLE -> SETUP -> ACCESS, all outputs registered.
// Define APB_MASTER_TIMEOUT_EN to force termination after TIMEOUT_CYCLES ACCESS cycles.
module apb_master #(
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned DATA_WIDTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic          pclk_i,
   input logic          prst_i,
   apb_master_if.master bus
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntWidth-1:0] TimeoutMax = CntWidth'(TIMEOUT_CYCLES - 1);

   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                rsp_timeout_q, rsp_timeout_d;
`endif

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_d         = cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         StIdle: begin
            if (bus.cmd_valid_i) begin
               state_d     = StSetup;
               cmd_ready_d = 1'b0;
               psel_d      = 1'b1;
               penable_d   = 1'b0;
               pwrite_d    = bus.cmd_write_i;
               paddr_d     = bus.cmd_addr_i;
               pwdata_d    = bus.cmd_wdata_i;
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_d = '0;
`endif
         end
         StAccess: begin
            // A real ready wins over a timeout landing in the same cycle.
            if (bus.pready_i) begin
               state_d     = StIdle;
               cmd_ready_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : bus.prdata_i;
               rsp_err_d   = bus.pslverr_i;
`ifdef APB_MASTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (cnt_q == TimeoutMax) begin
               state_d       = StIdle;
               cmd_ready_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b1;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         cnt_q         <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign bus.rsp_timeout_o = rsp_timeout_q;
`else
   assign bus.rsp_timeout_o = 1'b0;
`endif

   assign bus.cmd_ready_o = cmd_ready_q;
   assign bus.psel_o      = psel_q;
   assign bus.penable_o   = penable_q;
   assign bus.pwrite_o    = pwrite_q;
   assign bus.paddr_o     = paddr_q;
   assign bus.pwdata_o    = pwdata_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_rdata_o = rsp_rdata_q;
   assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: driver pushes expected responses, a monitor pops and checks them.
// Honours APB_MASTER_TIMEOUT_EN to pick the timeout or the wait-forever scenario.
module tb_apb_master;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 4;
   localparam int unsigned TO = 4;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      logic          tmo;
      int            due;
      int            acc;
   } exp_t;

   logic pclk = 1'b0;
   logic prst = 1'b1;

   apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_master #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .pclk_i(pclk),
      .prst_i(prst),
      .bus   (bus)
   );

   always #5 pclk = ~pclk;

   exp_t          sb[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            acc_run = 0;
   int            rsp_seen = 0;
   int            low_run = 0;
   int            last_gap = 0;
   int            sl_waits = 0;
   int            sl_cnt = 0;
   logic [DW-1:0] sl_prdata = '0;
   logic          sl_err = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_wdata = '0;
   logic          exp_write = 1'b0;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // APB responder: ready after sl_waits wait states, junk on the response lines otherwise.
   initial begin
      bus.pready_i  = 1'b0;
      bus.prdata_i  = '0;
      bus.pslverr_i = 1'b0;
      forever begin
         @(negedge pclk);
         if (bus.psel_o && bus.penable_o) begin
            if (sl_cnt >= sl_waits) begin
               bus.pready_i  = 1'b1;
               bus.prdata_i  = sl_prdata;
               bus.pslverr_i = sl_err;
            end else begin
               bus.pready_i  = 1'b0;
               bus.prdata_i  = ~sl_prdata;
               bus.pslverr_i = ~sl_err;
            end
            sl_cnt++;
         end else begin
            bus.pready_i  = 1'b0;
            bus.prdata_i  = 4'hD;
            bus.pslverr_i = 1'b1;
            sl_cnt        = 0;
         end
      end
   end

   // Monitor: bus stability, ACCESS length, psel gaps and scoreboard comparison.
   initial begin
      exp_t e;
      forever begin
         @(negedge pclk);
         if (bus.psel_o && !bus.penable_o) acc_run = 0;
         if (bus.psel_o) begin
            chk("paddr_hold", bus.paddr_o, exp_addr);
            chk("pwdata_hold", bus.pwdata_o, exp_wdata);
            chk("pwrite_hold", bus.pwrite_o, exp_write);
         end
         if (bus.psel_o && bus.penable_o) acc_run++;
         if (!bus.psel_o) begin
            low_run++;
         end else begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
         end
         if (bus.rsp_valid_o) begin
            rsp_seen++;
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("rsp_rdata", bus.rsp_rdata_o, e.rdata);
               chk("rsp_err", bus.rsp_err_o, e.err);
               chk("rsp_timeout", bus.rsp_timeout_o, e.tmo);
               chk("rsp_cycle", cyc, e.due);
               chk("access_len", acc_run, e.acc);
               chk("rsp_ready_same_cycle", bus.cmd_ready_o, 1);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge of the SETUP cycle.
   // mode 0: normal completion, 1: timeout expected, 2: no response expected.
   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] prd, input logic serr,
                        input int mode, output int accept);
      exp_t e;
      int   n;
      bus.cmd_write_i = wr;
      bus.cmd_addr_i  = addr;
      bus.cmd_wdata_i = wdata;
      bus.cmd_valid_i = 1'b1;
      n = 0;
      while (!bus.cmd_ready_o && n < 50) begin
         @(negedge pclk);
         n++;
      end
      chk("cmd_accepted", bus.cmd_ready_o, 1);
      accept    = cyc;
      exp_addr  = addr;
      exp_wdata = wdata;
      exp_write = wr;
      sl_waits  = waits;
      sl_prdata = prd;
      sl_err    = serr;
      if (mode == 0) begin
         e.rdata = wr ? '0 : prd;
         e.err   = serr;
         e.tmo   = 1'b0;
         e.due   = accept + 3 + waits;
         e.acc   = waits + 1;
         sb.push_back(e);
      end else if (mode == 1) begin
         e.rdata = '0;
         e.err   = 1'b1;
         e.tmo   = 1'b1;
         e.due   = accept + 3 + int'(TO) - 1;
         e.acc   = int'(TO);
         sb.push_back(e);
      end
      @(negedge pclk);
      bus.cmd_valid_i = 1'b0;
      chk("setup_psel", bus.psel_o, 1);
      chk("setup_penable", bus.penable_o, 0);
      chk("setup_paddr", bus.paddr_o, addr);
      chk("setup_pwdata", bus.pwdata_o, wdata);
      chk("setup_pwrite", bus.pwrite_o, wr);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge pclk);
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      int a1;
      int a2;
      int n;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_write_i = 1'b0;
      bus.cmd_addr_i  = '0;
      bus.cmd_wdata_i = '0;

      #1;
      chk("rst_psel", bus.psel_o, 0);
      chk("rst_penable", bus.penable_o, 0);
      chk("rst_rsp_valid", bus.rsp_valid_o, 0);
      chk("rst_paddr", bus.paddr_o, 0);
      chk("rst_rsp_err", bus.rsp_err_o, 0);
      repeat (2) @(negedge pclk);
      prst = 1'b0;
      @(negedge pclk);
      chk("rst_cmd_ready", bus.cmd_ready_o, 1);

      issue(1'b1, 4'h3, 4'hA, 0, 4'h6, 1'b0, 0, a1);
      wait_drain();
      issue(1'b0, 4'h5, 4'h2, 2, 4'h7, 1'b0, 0, a1);
      wait_drain();
      issue(1'b1, 4'hC, 4'h5, 0, 4'h9, 1'b1, 0, a1);
      wait_drain();
      issue(1'b0, 4'h2, 4'h0, 0, 4'hB, 1'b1, 0, a1);
      wait_drain();

      issue(1'b0, 4'hF, 4'h1, 0, 4'h3, 1'b0, 0, a1);
      issue(1'b1, 4'h0, 4'hF, 1, 4'h4, 1'b0, 0, a2);
      chk("b2b_accept_cycle", a2 - a1, 3);
      wait_drain();
      chk("b2b_psel_gap", last_gap, 1);

`ifdef APB_MASTER_TIMEOUT_EN
      issue(1'b0, 4'h8, 4'h1, 1000, 4'h9, 1'b0, 1, a1);
      wait_drain();
      issue(1'b0, 4'h6, 4'h3, 1000, 4'h9, 1'b0, 2, a1);
      repeat (2) @(negedge pclk);
`else
      issue(1'b0, 4'h6, 4'h3, 1000, 4'h9, 1'b0, 2, a1);
      n = rsp_seen;
      repeat (100) @(negedge pclk);
      chk("no_rsp_without_timeout", rsp_seen - n, 0);
      chk("still_access", bus.penable_o, 1);
`endif

      // Reset in the middle of ACCESS.
      n = rsp_seen;
      chk("pre_rst_access", bus.penable_o, 1);
      prst = 1'b1;
      #1;
      chk("midrst_psel", bus.psel_o, 0);
      chk("midrst_penable", bus.penable_o, 0);
      chk("midrst_paddr", bus.paddr_o, 0);
      @(negedge pclk);
      prst = 1'b0;
      @(negedge pclk);
      chk("postrst_cmd_ready", bus.cmd_ready_o, 1);
      chk("postrst_psel", bus.psel_o, 0);
      repeat (3) @(negedge pclk);
      chk("no_rsp_after_abort", rsp_seen - n, 0);

      issue(1'b0, 4'h9, 4'h0, 1, 4'hE, 1'b0, 0, a1);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
